pc_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute controller that drives the program counter's inc and jump controls.
- Runs an instruction-memory request/ready handshake, latches the instruction register, and hands ALU-type instructions to the execute datapath through an exec_start/exec_done handshake.
- Handles conditional-jump and halt opcodes locally.
- Sits between the PC, instruction memory and the datapath control decoder.

---
 rtl/pc_seq_pkg.sv | 23 ++
 rtl/pc_sequencer_exec_watchdog.sv | 40 ++++
 rtl/pc_sequencer.sv | 156 +++++++++++++++
 tb/tb_pc_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared state encoding and opcode constants for the pc sequencer
package pc_seq_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OPC_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OPC_JMPZ = 4'h1;
    localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    // Anything that is not handled locally by the sequencer goes to the datapath.
    function automatic logic is_exec_class(input logic [OPC_W-1:0] opc);
        return !(opc == OPC_NOP || opc == OPC_JMPZ || opc == OPC_HALT);
    endfunction

endpackage

// File: rtl/pc_sequencer_exec_watchdog.sv
// rtl/pc_sequencer_exec_watchdog.sv - bounded wait counter for the execute handshake
module exec_watchdog #(
    parameter int EXEC_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(EXEC_TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST = CW'(EXEC_TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Expired once the count has reached the last permitted wait cycle.
    assign expired_o = (cnt_q == LAST);

    // Clear wins over enable; the count parks at LAST so it can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/decode/execute controller driving PC inc/jump strobes
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int EXEC_TIMEOUT = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    output logic             imem_req_o,
    input  logic             imem_ready_i,
    input  logic [15:0]      imem_rdata_i,
    input  logic             z_flag_i,
    output logic             exec_start_o,
    input  logic             exec_done_i,
    output logic             pc_inc_o,
    output logic             pc_jump_o,
    output logic [15:0]      ir_o,
    output logic             busy_o,
    output logic             halted_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] retired_o
);

    state_e           state_q, state_d;
    logic [15:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             pc_inc_q, pc_inc_d;
    logic             pc_jump_q, pc_jump_d;
    logic             exec_start_q, exec_start_d;
    logic             fault_q, fault_d;

    logic             wd_clear;
    logic             wd_enable;
    logic             wd_expired;
    logic [OPC_W-1:0] opc;

    assign opc = ir_q[15 -: OPC_W];

    exec_watchdog #(
        .EXEC_TIMEOUT (EXEC_TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );

    // Next state, instruction latch, retire count and next-cycle strobes.
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        retired_d    = retired_q;
        pc_inc_d     = 1'b0;
        pc_jump_d    = 1'b0;
        exec_start_d = 1'b0;
        fault_d      = fault_q;
        wd_clear     = 1'b0;
        wd_enable    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (imem_ready_i) begin
                    ir_d    = imem_rdata_i;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (is_exec_class(opc)) begin
                    exec_start_d = 1'b1;
                    wd_clear     = 1'b1;
                    state_d      = ST_EXEC;
                end else begin
                    retired_d = retired_q + CNT_W'(1);
                    if (opc == OPC_HALT) begin
                        state_d = ST_HALTED;
                    end else begin
                        // z_flag only matters here, in the single decode cycle.
                        if (opc == OPC_JMPZ && z_flag_i) begin
                            pc_jump_d = 1'b1;
                        end else begin
                            pc_inc_d = 1'b1;
                        end
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_EXEC: begin
                // A completion arriving on the last permitted cycle still counts.
                if (exec_done_i) begin
                    pc_inc_d  = 1'b1;
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = ST_FETCH;
                end else if (wd_expired) begin
                    fault_d = 1'b1;
                    state_d = ST_HALTED;
                end else begin
                    wd_enable = 1'b1;
                end
            end

            ST_HALTED: begin
                if (start_i) begin
                    fault_d = 1'b0;
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any strobe in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ir_q         <= '0;
            retired_q    <= '0;
            pc_inc_q     <= 1'b0;
            pc_jump_q    <= 1'b0;
            exec_start_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            retired_q    <= retired_d;
            pc_inc_q     <= pc_inc_d;
            pc_jump_q    <= pc_jump_d;
            exec_start_q <= exec_start_d;
            fault_q      <= fault_d;
        end
    end

    assign imem_req_o   = (state_q == ST_FETCH);
    assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    assign halted_o     = (state_q == ST_HALTED);
    assign exec_start_o = exec_start_q;
    assign pc_inc_o     = pc_inc_q;
    assign pc_jump_o    = pc_jump_q;
    assign ir_o         = ir_q;
    assign fault_o      = fault_q;
    assign retired_o    = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer
module tb_pc_sequencer;

    localparam int EXEC_TIMEOUT = 16;
    localparam int CNT_W        = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             imem_req;
    logic             imem_ready;
    logic [15:0]      imem_rdata;
    logic             z_flag;
    logic             exec_start;
    logic             exec_done;
    logic             pc_inc;
    logic             pc_jump;
    logic [15:0]      ir;
    logic             busy;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-instruction transaction state of the reference model.
    logic [15:0] cur_ir;
    logic        cur_z;
    int          cur_k;
    bit          have_cur;
    int          n_inc, n_jump, n_es;
    int          exp_retired;
    int          n_instr;
    int          done_cd;
    bit          prev_inc, prev_jump;

    always #5 clk = ~clk;

    pc_sequencer #(
        .EXEC_TIMEOUT (EXEC_TIMEOUT),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start),
        .imem_req_o   (imem_req),
        .imem_ready_i (imem_ready),
        .imem_rdata_i (imem_rdata),
        .z_flag_i     (z_flag),
        .exec_start_o (exec_start),
        .exec_done_i  (exec_done),
        .pc_inc_o     (pc_inc),
        .pc_jump_o    (pc_jump),
        .ir_o         (ir),
        .busy_o       (busy),
        .halted_o     (halted),
        .fault_o      (fault),
        .retired_o    (retired)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_instr();
        int          r;
        logic [15:0] w;
        r = $urandom_range(0, 15);
        w = 16'($urandom);
        if (r < 3)       w[15:12] = 4'h0;
        else if (r < 7)  w[15:12] = 4'h1;
        else if (r == 7) w[15:12] = 4'hF;
        else if (w[15:12] inside {4'h0, 4'h1, 4'hF}) w[15:12] = 4'h7;
        return w;
    endfunction

    // Closes out the outstanding instruction: compares what was observed since
    // its fetch against what the opcode rules say it must have produced.
    task automatic retire_check(input bit at_halt);
        logic [3:0] opc;
        int         e_inc, e_jump, e_es;
        bit         e_halt, e_fault;
        opc     = cur_ir[15:12];
        e_inc   = 0;
        e_jump  = 0;
        e_es    = 0;
        e_halt  = 0;
        e_fault = 0;
        if (opc == 4'h0) begin
            e_inc = 1;
        end else if (opc == 4'h1) begin
            if (cur_z) e_jump = 1;
            else       e_inc  = 1;
        end else if (opc == 4'hF) begin
            e_halt = 1;
        end else begin
            e_es = 1;
            if (cur_k > EXEC_TIMEOUT - 1) begin
                e_halt  = 1;
                e_fault = 1;
            end else begin
                e_inc = 1;
            end
        end
        if (!e_fault) exp_retired++;
        check_val("stop_point", 32'(at_halt), 32'(e_halt));
        check_val("pc_inc_count", n_inc, e_inc);
        check_val("pc_jump_count", n_jump, e_jump);
        check_val("exec_start_count", n_es, e_es);
        check_val("retired", 32'(retired), exp_retired % 65536);
        check_val("ir", 32'(ir), 32'(cur_ir));
        check_val("fault", 32'(fault), 32'(e_fault));
        n_instr++;
    endtask

    // Bench plays instruction memory and datapath for a random program.
    task automatic run_random(input int n_target, input int max_cycles);
        int cyc;
        cyc      = 0;
        have_cur = 0;
        n_instr  = 0;
        done_cd  = -1;
        prev_inc = 0;
        prev_jump = 0;
        n_inc = 0; n_jump = 0; n_es = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (n_instr < n_target && cyc < max_cycles) begin
            if (pc_inc || pc_jump) check_val("strobe_exclusive", 32'(pc_inc & pc_jump), 0);
            if (pc_inc) begin
                check_val("pc_inc_width", 32'(prev_inc), 0);
                n_inc++;
            end
            if (pc_jump) begin
                check_val("pc_jump_width", 32'(prev_jump), 0);
                n_jump++;
            end
            if (exec_start) begin
                n_es++;
                done_cd = cur_k;
            end
            prev_inc  = pc_inc;
            prev_jump = pc_jump;

            start     = ($urandom_range(0, 7) == 0);
            exec_done = 1'b0;
            if (halted) begin
                if (have_cur) retire_check(1'b1);
                else          check_val("unexpected_halt", 1, 0);
                check_val("busy_in_halt", 32'(busy), 0);
                have_cur = 0;
                done_cd  = -1;
                start    = 1'b1;
            end

            if (done_cd == 0) begin
                exec_done = 1'b1;
                done_cd   = -1;
            end else if (done_cd > 0) begin
                done_cd--;
            end else if (imem_req && $urandom_range(0, 3) == 0) begin
                exec_done = 1'b1;
            end

            imem_ready = 1'b0;
            imem_rdata = 16'($urandom);
            if (imem_req && $urandom_range(0, 3) != 0) begin
                if (have_cur) retire_check(1'b0);
                cur_ir = rand_instr();
                cur_z  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) cur_k = $urandom_range(14, 17);
                else                           cur_k = $urandom_range(0, 8);
                imem_ready = 1'b1;
                imem_rdata = cur_ir;
                z_flag     = cur_z;
                n_inc = 0; n_jump = 0; n_es = 0;
                have_cur = 1;
            end
            tick();
            cyc++;
        end
        check_val("random_progress", 32'(n_instr >= n_target), 1);
        start      = 1'b0;
        exec_done  = 1'b0;
        imem_ready = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        imem_ready  = 1'b0;
        imem_rdata  = 16'h0000;
        z_flag      = 1'b0;
        exec_done   = 1'b0;
        exp_retired = 0;
        repeat (3) tick();
        check_val("rst_imem_req", 32'(imem_req), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_halted", 32'(halted), 0);
        check_val("rst_fault", 32'(fault), 0);
        check_val("rst_retired", 32'(retired), 0);
        check_val("rst_ir", 32'(ir), 0);
        check_val("rst_strobes", {29'd0, pc_inc, pc_jump, exec_start}, 0);
        reset = 1'b0;
        tick();
        check_val("idle_without_start", 32'(busy), 0);

        run_random(300, 20000);

        // Fetch stall, then reset while waiting on the datapath.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("reset2_retired", 32'(retired), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_val("imem_req_held", 32'(imem_req), 1);
            tick();
        end
        imem_ready = 1'b1;
        imem_rdata = 16'h2345;
        tick();
        imem_ready = 1'b0;
        check_val("ir_latched", 32'(ir), 32'h2345);
        tick();
        check_val("exec_start_pulse", 32'(exec_start), 1);
        tick();
        check_val("exec_start_single", 32'(exec_start), 0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("abort_busy", 32'(busy), 0);
        check_val("abort_retired", 32'(retired), 0);
        check_val("abort_ir", 32'(ir), 0);
        check_val("abort_strobes", {29'd0, pc_inc, pc_jump, exec_start}, 0);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        check_val("late_done_busy", 32'(busy), 0);
        check_val("late_done_inc", 32'(pc_inc), 0);
        check_val("late_done_retired", 32'(retired), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
